// File: rtl/riscv_mem_arbiter_pkg.sv
// riscv_mem_arbiter_pkg
//   Shared definitions for the imem/dmem memory arbiter: default message
//   widths (32-bit address/data vc-mem request/response layouts), default
//   in-flight depth, and the source-ID encoding stored in the ID queue.
package riscv_mem_arbiter_pkg;

  localparam int REQ_SZ_DFLT    = 67;  // vc mem request msg, 32-bit addr / 32-bit data
  localparam int RESP_SZ_DFLT   = 35;  // vc mem response msg, 32-bit data
  localparam int MAX_OUTST_DFLT = 4;

  // Which core port issued a request; also the arbitration priority value.
  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_idq.sv
// riscv_mem_arbiter_idq
//   1-bit-wide, DEPTH-deep FIFO of source IDs for requests that have been
//   sent to memory and are still waiting for their (in-order) response.
// Ports
//   clk, reset        clock, asynchronous active-high reset (clears pointers/count)
//   push, push_id     enqueue push_id (ignored when full)
//   pop               dequeue the head entry (ignored when empty)
//   full, empty       occupancy flags from the registered count
//   head              ID at the head of the queue (valid when !empty)
module riscv_mem_arbiter_idq
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          id_mem [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = id_mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap mod DEPTH on their
  // own; the separate count distinguishes full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) id_mem[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
//   Merges the core's imem and dmem val/rdy request ports onto one shared
//   memory port (round-robin, zero added latency) and steers the in-order
//   memory responses back to the port that issued each request.
// Ports
//   clk, reset                         clock, asynchronous active-high reset
//   imemreq_msg/val/rdy                instruction request port (from core)
//   imemresp_msg/val                   instruction response port (to core)
//   dmemreq_msg/val/rdy                data request port (from core)
//   dmemresp_msg/val                   data response port (to core)
//   memreq_msg/val/rdy                 shared memory request port
//   memresp_msg/val                    shared memory response (always accepted)
//   resp_err                           sticky: response seen with nothing outstanding
//   perf_icnt, perf_dcnt, perf_conf    imem grants, dmem grants, conflict cycles
// Configuration
//   RISCV_MEMARB_PERF_EN  when defined, the perf_* counters are implemented;
//                         otherwise the perf_* outputs are constant zero.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int REQ_SZ    = REQ_SZ_DFLT,
  parameter int RESP_SZ   = RESP_SZ_DFLT,
  parameter int MAX_OUTST = MAX_OUTST_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_SZ-1:0]  imemreq_msg,
  input  logic               imemreq_val,
  output logic               imemreq_rdy,
  output logic [RESP_SZ-1:0] imemresp_msg,
  output logic               imemresp_val,
  input  logic [REQ_SZ-1:0]  dmemreq_msg,
  input  logic               dmemreq_val,
  output logic               dmemreq_rdy,
  output logic [RESP_SZ-1:0] dmemresp_msg,
  output logic               dmemresp_val,
  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,
  output logic               resp_err,
  output logic [31:0]        perf_icnt,
  output logic [31:0]        perf_dcnt,
  output logic [31:0]        perf_conf
);

  src_e prio_q, prio_d;
  logic resp_err_q, resp_err_d;
  logic full, empty, head;
  logic gnt_i, gnt_d;
  logic sel_dmem;
  logic fire, pop;

  // A port's grant never looks at its own val, so rdy has no path from the
  // same port's val.
  assign gnt_i = ~full & (~dmemreq_val | (prio_q == SRC_IMEM));
  assign gnt_d = ~full & (~imemreq_val | (prio_q == SRC_DMEM));

  assign imemreq_rdy = memreq_rdy & gnt_i;
  assign dmemreq_rdy = memreq_rdy & gnt_d;

  // dmem is selected unless imem is both valid and granted.
  assign sel_dmem   = ~(imemreq_val & gnt_i);
  assign memreq_val = ~full & (imemreq_val | dmemreq_val);
  assign memreq_msg = sel_dmem ? dmemreq_msg : imemreq_msg;
  assign fire       = memreq_val & memreq_rdy;

  // Empty is sampled before this cycle's push, so a response arriving in
  // the same cycle as the first request is treated as stray.
  assign pop          = memresp_val & ~empty;
  assign imemresp_val = pop & (head == SRC_IMEM);
  assign dmemresp_val = pop & (head == SRC_DMEM);
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign resp_err     = resp_err_q;

  riscv_mem_arbiter_idq #(
    .DEPTH (MAX_OUTST)
  ) u_idq (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (sel_dmem),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // Priority only moves on an accepted request; a stalled winner keeps it.
  always_comb begin
    prio_d     = prio_q;
    resp_err_d = resp_err_q;
    if (fire) prio_d = other_src(src_e'(sel_dmem));
    if (memresp_val & empty) resp_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= SRC_IMEM;
      resp_err_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      resp_err_q <= resp_err_d;
    end
  end

`ifdef RISCV_MEMARB_PERF_EN
  logic [31:0] perf_icnt_q, perf_icnt_d;
  logic [31:0] perf_dcnt_q, perf_dcnt_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  always_comb begin
    perf_icnt_d = perf_icnt_q;
    perf_dcnt_d = perf_dcnt_q;
    perf_conf_d = perf_conf_q;
    if (fire & ~sel_dmem) perf_icnt_d = perf_icnt_q + 32'd1;
    if (fire & sel_dmem)  perf_dcnt_d = perf_dcnt_q + 32'd1;
    if (imemreq_val & dmemreq_val & ~full & memreq_rdy)
      perf_conf_d = perf_conf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_icnt_q <= '0;
      perf_dcnt_q <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_icnt_q <= perf_icnt_d;
      perf_dcnt_q <= perf_dcnt_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_icnt = perf_icnt_q;
  assign perf_dcnt = perf_dcnt_q;
  assign perf_conf = perf_conf_q;
`else
  assign perf_icnt = 32'b0;
  assign perf_dcnt = 32'b0;
  assign perf_conf = 32'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
//   Directed, table-driven bench for riscv_mem_arbiter. Each table record
//   holds the inputs for one cycle and the outputs expected before the
//   following rising edge; a hand-written sequence covers asynchronous reset
//   in the middle of traffic. Honors RISCV_MEMARB_PERF_EN for the counters.
module tb_riscv_mem_arbiter;

  localparam int REQ_SZ  = 67;
  localparam int RESP_SZ = 35;

`ifdef RISCV_MEMARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [REQ_SZ-1:0]  imemreq_msg, dmemreq_msg, memreq_msg;
  logic               imemreq_val, imemreq_rdy, dmemreq_val, dmemreq_rdy;
  logic [RESP_SZ-1:0] imemresp_msg, dmemresp_msg, memresp_msg;
  logic               imemresp_val, dmemresp_val;
  logic               memreq_val, memreq_rdy, memresp_val;
  logic               resp_err;
  logic [31:0]        perf_icnt, perf_dcnt, perf_conf;

  riscv_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .imemreq_msg  (imemreq_msg),
    .imemreq_val  (imemreq_val),
    .imemreq_rdy  (imemreq_rdy),
    .imemresp_msg (imemresp_msg),
    .imemresp_val (imemresp_val),
    .dmemreq_msg  (dmemreq_msg),
    .dmemreq_val  (dmemreq_val),
    .dmemreq_rdy  (dmemreq_rdy),
    .dmemresp_msg (dmemresp_msg),
    .dmemresp_val (dmemresp_val),
    .memreq_msg   (memreq_msg),
    .memreq_val   (memreq_val),
    .memreq_rdy   (memreq_rdy),
    .memresp_msg  (memresp_msg),
    .memresp_val  (memresp_val),
    .resp_err     (resp_err),
    .perf_icnt    (perf_icnt),
    .perf_dcnt    (perf_dcnt),
    .perf_conf    (perf_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs {rst,iv,dv,mrdy,rv}; expected {irdy,drdy,mval,sel,irv,drv,err}.
  // rst pulses reset before the inputs are applied; sel 0=imem 1=dmem (checked when mval).
  typedef struct packed {
    logic rst, iv, dv, mrdy, rv;
    logic e_irdy, e_drdy, e_mval, e_sel, e_irv, e_drv, e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_passed = 0;
  int   m_icnt, m_dcnt, m_conf;

  function automatic vec_t mk(input logic [4:0] in, input logic [6:0] ex);
    return vec_t'({in, ex});
  endfunction

  function automatic logic [REQ_SZ-1:0] i_msg(input int k);
    return {3'b000, 32'(k * 4), 32'hA000_0000 | 32'(k)};
  endfunction

  function automatic logic [REQ_SZ-1:0] d_msg(input int k);
    return {3'b001, 32'h100 + 32'(k * 4), 32'hD000_0000 | 32'(k)};
  endfunction

  function automatic logic [RESP_SZ-1:0] r_msg(input int k);
    return {3'b000, 32'h5000_0000 | 32'(k)};
  endfunction

  task automatic check(input string name, input logic [REQ_SZ-1:0] act,
                       input logic [REQ_SZ-1:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_passed++;
  endtask

  task automatic drive(input int k, input logic iv, input logic dv,
                       input logic mrdy, input logic rv);
    imemreq_val = iv;
    dmemreq_val = dv;
    memreq_rdy  = mrdy;
    memresp_val = rv;
    imemreq_msg = i_msg(k);
    dmemreq_msg = d_msg(k);
    memresp_msg = r_msg(k);
  endtask

  task automatic check_perf(input string tag);
    check({tag, " perf_icnt"}, 67'(perf_icnt), PERF ? 67'(m_icnt) : 67'd0);
    check({tag, " perf_dcnt"}, 67'(perf_dcnt), PERF ? 67'(m_dcnt) : 67'd0);
    check({tag, " perf_conf"}, 67'(perf_conf), PERF ? 67'(m_conf) : 67'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_icnt = 0; m_dcnt = 0; m_conf = 0;

    // imem only: three reads, each response one cycle later
    vecs.push_back(mk(5'b10000, 7'b0000000));
    vecs.push_back(mk(5'b01010, 7'b1010000));
    vecs.push_back(mk(5'b01011, 7'b1110100));
    vecs.push_back(mk(5'b01011, 7'b1110100));
    vecs.push_back(mk(5'b00011, 7'b1100100));
    // both valid every cycle, response latency 2: I,D,I,D,I
    vecs.push_back(mk(5'b11110, 7'b1010000));
    vecs.push_back(mk(5'b01110, 7'b0111000));
    vecs.push_back(mk(5'b01111, 7'b1010100));
    vecs.push_back(mk(5'b01111, 7'b0111010));
    vecs.push_back(mk(5'b01111, 7'b1010100));
    vecs.push_back(mk(5'b00011, 7'b1100010));
    vecs.push_back(mk(5'b00011, 7'b1100100));
    // fill to 4 outstanding, stall, one pop frees a slot, refill, drain
    vecs.push_back(mk(5'b11110, 7'b1010000));
    vecs.push_back(mk(5'b01110, 7'b0111000));
    vecs.push_back(mk(5'b01110, 7'b1010000));
    vecs.push_back(mk(5'b01110, 7'b0111000));
    vecs.push_back(mk(5'b01110, 7'b0000000));
    vecs.push_back(mk(5'b01111, 7'b0000100));
    vecs.push_back(mk(5'b01110, 7'b1010000));
    vecs.push_back(mk(5'b00010, 7'b0000000));
    vecs.push_back(mk(5'b00011, 7'b0000010));
    vecs.push_back(mk(5'b00011, 7'b1100100));
    vecs.push_back(mk(5'b00011, 7'b1100010));
    vecs.push_back(mk(5'b00011, 7'b1100100));
    // memreq_rdy low: winner (dmem) must keep priority until accepted
    vecs.push_back(mk(5'b01100, 7'b0011000));
    vecs.push_back(mk(5'b01110, 7'b0111000));
    vecs.push_back(mk(5'b00011, 7'b1100010));
    // stray response on empty queue: dropped, resp_err sticky
    vecs.push_back(mk(5'b00011, 7'b1100000));
    vecs.push_back(mk(5'b00000, 7'b0000001));
    vecs.push_back(mk(5'b00000, 7'b0000001));
    // interleave D,I,D then R1->dmem, R2->imem, R3->dmem
    vecs.push_back(mk(5'b10110, 7'b1111000));
    vecs.push_back(mk(5'b01010, 7'b1010000));
    vecs.push_back(mk(5'b00110, 7'b0111000));
    vecs.push_back(mk(5'b00011, 7'b1100010));
    vecs.push_back(mk(5'b00011, 7'b1100100));
    vecs.push_back(mk(5'b00011, 7'b1100010));

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      if (v.rst) begin
        drive(i, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_icnt = 0; m_dcnt = 0; m_conf = 0;
      end
      drive(i, v.iv, v.dv, v.mrdy, v.rv);
      #1;
      $display("vec %0d in iv=%b dv=%b mrdy=%b rv=%b -> irdy=%b drdy=%b mval=%b irv=%b drv=%b err=%b",
               i, v.iv, v.dv, v.mrdy, v.rv, imemreq_rdy, dmemreq_rdy, memreq_val,
               imemresp_val, dmemresp_val, resp_err);
      check($sformatf("v%0d imemreq_rdy", i), 67'(imemreq_rdy), 67'(v.e_irdy));
      check($sformatf("v%0d dmemreq_rdy", i), 67'(dmemreq_rdy), 67'(v.e_drdy));
      check($sformatf("v%0d memreq_val", i), 67'(memreq_val), 67'(v.e_mval));
      if (v.e_mval)
        check($sformatf("v%0d memreq_msg", i), memreq_msg, v.e_sel ? d_msg(i) : i_msg(i));
      check($sformatf("v%0d imemresp_val", i), 67'(imemresp_val), 67'(v.e_irv));
      check($sformatf("v%0d dmemresp_val", i), 67'(dmemresp_val), 67'(v.e_drv));
      if (v.e_irv) check($sformatf("v%0d imemresp_msg", i), 67'(imemresp_msg), 67'(r_msg(i)));
      if (v.e_drv) check($sformatf("v%0d dmemresp_msg", i), 67'(dmemresp_msg), 67'(r_msg(i)));
      check($sformatf("v%0d resp_err", i), 67'(resp_err), 67'(v.e_err));
      check_perf($sformatf("v%0d", i));
      // counter model advances on this cycle's expected fire / conflict
      if (v.e_mval && v.mrdy) begin
        if (v.e_sel) m_dcnt++;
        else         m_icnt++;
      end
      if (v.iv && v.dv && v.mrdy && v.e_mval) m_conf++;
    end

    // Asynchronous reset mid-cycle with two requests outstanding and prio=DMEM
    @(negedge clk);
    drive(100, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    drive(100, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("ar fire D memreq_msg", memreq_msg, d_msg(100));
    @(negedge clk);
    drive(101, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("ar fire I memreq_msg", memreq_msg, i_msg(101));
    @(negedge clk);
    drive(102, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("ar pre-reset dmemreq_rdy", 67'(dmemreq_rdy), 67'd1);
    check("ar pre-reset memreq_msg", memreq_msg, d_msg(102));
    #1;
    reset = 1'b1;
    #1;
    $display("async reset asserted at %0t with 2 outstanding", $time);
    check("ar in-reset imemreq_rdy", 67'(imemreq_rdy), 67'd1);
    check("ar in-reset dmemreq_rdy", 67'(dmemreq_rdy), 67'd0);
    check("ar in-reset memreq_msg", memreq_msg, i_msg(102));
    check("ar in-reset resp_err", 67'(resp_err), 67'd0);
    m_icnt = 0; m_dcnt = 0; m_conf = 0;
    check_perf("ar in-reset");
    @(negedge clk);
    reset = 1'b0;
    drive(103, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("ar stray imemresp_val", 67'(imemresp_val), 67'd0);
    check("ar stray dmemresp_val", 67'(dmemresp_val), 67'd0);
    @(negedge clk);
    drive(104, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ar resp_err set", 67'(resp_err), 67'd1);
    repeat (3) @(negedge clk);
    drive(105, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("ar resp_err sticky", 67'(resp_err), 67'd1);
    check("ar prio imem imemreq_rdy", 67'(imemreq_rdy), 67'd1);
    check("ar prio imem memreq_msg", memreq_msg, i_msg(105));

    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
